// File: rtl/l0_line_fill.sv
`default_nettype none
// ============================================================================
// Module   : l0_line_fill
// Purpose  : Line-fill responder for cacheL0 instruction misses. A fetch
//            request triggers a 16-word burst read from the backing memory.
//            The returned words are collected in a local line buffer. The
//            line is then streamed into the L0 store port as 16
//            back-to-back beats.
// Ports    : clock_i / reset_ni      - clock, async active-low reset
//            fetch_i, line_i         - L0 miss request and missed line index
//            flush_i                 - cancel the fill in progress
//            busy_o                  - high in every state except IDLE
//            store_o, addr_o, data_o - L0 store port (one word per beat)
//            mem_req_o, mem_addr_o   - burst read request and line base
//            mem_gnt_i               - memory accepted the request
//            mem_valid_i, mem_data_i - returned words, offset 0..15 in order
// Revision : 1.0 - initial release
// ============================================================================
module l0_line_fill #(
  parameter int ADDR_WIDTH = 16,
  parameter int WIDTH      = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  fetch_i,
  input  logic [ADDR_WIDTH-5:0] line_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  store_o,
  output logic [3:0]            addr_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_valid_i,
  input  logic [WIDTH-1:0]      mem_data_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_FILL   = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t                r_state;
  logic [3:0]            r_count;
  logic [ADDR_WIDTH-5:0] r_line;
  logic [WIDTH-1:0]      r_buf [16];

  logic                  w_buf_we;
  logic [3:0]            w_count_inc;

  assign w_buf_we    = (r_state == S_FILL) && mem_valid_i;
  assign w_count_inc = r_count + 4'd1;

  // Driven straight from the line register, so it is registered and stable
  // for the whole request phase.
  assign mem_addr_o  = {r_line, 4'h0};

  // Line buffer: no reset, contents persist between fills.
  always_ff @(posedge clock_i) begin
    if (w_buf_we) begin
      r_buf[r_count] <= mem_data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= S_IDLE;
      r_count   <= 4'd0;
      r_line    <= '0;
      busy_o    <= 1'b0;
      store_o   <= 1'b0;
      addr_o    <= 4'd0;
      data_o    <= '0;
      mem_req_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_i && !flush_i) begin
            r_state   <= S_REQ;
            r_line    <= line_i;
            r_count   <= 4'd0;
            mem_req_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end

        S_REQ: begin
          if (mem_gnt_i) begin
            // A granted burst must be consumed even when cancelled.
            mem_req_o <= 1'b0;
            r_state   <= flush_i ? S_DRAIN : S_FILL;
          end else if (flush_i) begin
            mem_req_o <= 1'b0;
            busy_o    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        S_FILL: begin
          if (mem_valid_i) begin
            r_count <= w_count_inc;
          end
          if (mem_valid_i && (r_count == 4'd15)) begin
            if (flush_i) begin
              // Last beat already arrived: nothing left to drain.
              busy_o  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              // buf[0] was written many cycles ago, so the first stream
              // beat can be presented straight away.
              r_state <= S_STREAM;
              store_o <= 1'b1;
              addr_o  <= 4'd0;
              data_o  <= r_buf[0];
            end
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end
        end

        S_STREAM: begin
          // r_count is the offset currently presented on addr_o/data_o.
          if (flush_i || (r_count == 4'd15)) begin
            store_o <= 1'b0;
            busy_o  <= 1'b0;
            r_count <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_count <= w_count_inc;
            addr_o  <= w_count_inc;
            data_o  <= r_buf[w_count_inc];
          end
        end

        S_DRAIN: begin
          if (mem_valid_i) begin
            r_count <= w_count_inc;
            if (r_count == 4'd15) begin
              busy_o  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          busy_o    <= 1'b0;
          store_o   <= 1'b0;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
